// File: rtl/dec_pkg.sv
// Shared definitions for the dec_scan decoder/scanner.
// Mode constants, scan FSM states and the one-hot helper.
package dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports
    localparam int MAX_N = 8;

    typedef enum logic {
        ST_DIRECT,
        ST_SCAN
    } scan_st_e;

    function automatic logic [2**MAX_N-1:0] onehot(
        input logic [MAX_N-1:0] sel
    );
        logic [2**MAX_N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_scan_prescaler.sv
// Scan prescaler: counts 0..DIV-1 while run is high, ticks on DIV-1.
// clear has priority and restarts the count; idle cycles hold it.
module dec_scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = run && (cnt_q == CNT_TOP);
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with an autonomous scan mode.
// Define DEC_SCAN_ACTIVE_LOW_EN for active-low (one-zero) Y.
module dec_scan
    import dec_pkg::*;
#(
    parameter int N    = 3,
    parameter int DIV  = 4,
    parameter int LAST = 2**N - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    Din,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int OUT_W = 2**N;

`ifdef DEC_SCAN_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    localparam logic [OUT_W-1:0] Y_IDLE   = ACT_LOW ? '1 : '0;
    localparam logic [N-1:0]     LAST_IDX = N'(LAST);

    if (DIV < 1) begin : g_bad_div
        $error("dec_scan: DIV must be >= 1");
    end
    if (LAST < 0 || LAST >= 2**N) begin : g_bad_last
        $error("dec_scan: LAST must be within 0..2**N-1");
    end
    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("dec_scan: N out of supported range");
    end

    function automatic logic [OUT_W-1:0] drive(input logic [N-1:0] s);
        logic [OUT_W-1:0] oh;
        oh = OUT_W'(onehot(MAX_N'(s)));
        return ACT_LOW ? ~oh : oh;
    endfunction

    scan_st_e         st_q;
    scan_st_e         st_d;
    logic [OUT_W-1:0] y_q;
    logic [OUT_W-1:0] y_d;
    logic [N-1:0]     idx_q;
    logic [N-1:0]     idx_d;
    logic             wrap_q;
    logic             wrap_d;

    logic pre_clear;
    logic pre_run;
    logic tick;

    logic is_direct;
    logic is_entry;
    logic is_scan;

    assign is_direct = en && (mode == MODE_DIRECT);
    assign is_entry  = en && (mode == MODE_SCAN) && (st_q == ST_DIRECT);
    assign is_scan   = en && (mode == MODE_SCAN) && (st_q == ST_SCAN);

    dec_scan_prescaler #(
        .DIV (DIV)
    ) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pre_clear),
        .run   (pre_run),
        .tick  (tick)
    );

    // en=0 falls to the default: outputs idle, idx/state/prescaler hold
    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        y_d       = Y_IDLE;
        wrap_d    = 1'b0;
        pre_clear = 1'b0;
        pre_run   = 1'b0;
        unique case (1'b1)
            is_direct: begin
                st_d      = ST_DIRECT;
                idx_d     = Din;
                y_d       = drive(Din);
                pre_clear = 1'b1;
            end
            is_entry: begin
                st_d      = ST_SCAN;
                idx_d     = '0;
                y_d       = drive('0);
                pre_clear = 1'b1;
            end
            is_scan: begin
                pre_run = 1'b1;
                if (tick) begin
                    wrap_d = (idx_q == LAST_IDX);
                    idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + N'(1);
                end
                y_d = drive(idx_d);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_DIRECT;
            y_q    <= Y_IDLE;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            y_q    <= y_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign Y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Testbench for dec_scan: vector table, scan sequences, random vs model.
// Polarity of Y follows DEC_SCAN_ACTIVE_LOW_EN.
module tb_dec_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       en_a, mode_a;
    logic [2:0] din_a;
    logic [7:0] y_a;
    logic [2:0] idx_a;
    logic       wrap_a;

    logic       en_b, mode_b;
    logic [2:0] din_b;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    dec_scan #(.N(3), .DIV(4), .LAST(5)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .Din(din_a),
        .Y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    dec_scan #(.N(3), .DIV(1), .LAST(7)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .Din(din_b),
        .Y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pol(input logic [7:0] ah);
`ifdef DEC_SCAN_ACTIVE_LOW_EN
        return ~ah;
`else
        return ah;
`endif
    endfunction

    function automatic logic [7:0] oh8(input int k);
        logic [7:0] v;
        v = 8'h01 << k;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: scan position derived from count of running cycles
    localparam int M_DIV = 4;
    localparam int M_LAST = 5;
    bit m_scan;
    int m_cnt;
    int m_idx;
    bit m_act;
    bit m_wrap;

    task automatic model_step(input bit e, input bit m, input int d);
        m_wrap = 1'b0;
        if (!e) begin
            m_act = 1'b0;
        end else begin
            m_act = 1'b1;
            if (!m) begin
                m_scan = 1'b0;
                m_idx = d;
            end else if (!m_scan) begin
                m_scan = 1'b1;
                m_cnt = 0;
                m_idx = 0;
            end else begin
                m_cnt++;
                m_idx = (m_cnt / M_DIV) % (M_LAST + 1);
                m_wrap = (m_cnt % M_DIV == 0) && (m_idx == 0);
            end
        end
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] din;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    vec_t tv[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tv[i] = '{1'b1, 1'b0, 3'(i), oh8(i), 3'(i), 1'b0};
        end
        tv[8]  = '{1'b0, 1'b0, 3'd5, 8'h00, 3'd7, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0};
        tv[10] = '{1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0};
        tv[11] = '{1'b0, 1'b1, 3'd6, 8'h00, 3'd2, 1'b0};
        tv[12] = '{1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b0};

        rst_n = 1'b0;
        en_a = 1'b0; mode_a = 1'b0; din_a = '0;
        en_b = 1'b1; mode_b = 1'b0; din_b = '0;
        #12;
        chk("rst_y_a", y_a, pol(8'h00));
        chk("rst_idx_a", idx_a, 0);
        chk("rst_wrap_a", wrap_a, 0);
        chk("rst_y_b", y_b, pol(8'h00));
        chk("rst_idx_b", idx_b, 0);
        chk("rst_wrap_b", wrap_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 13; i++) begin
            en_a = tv[i].en; mode_a = tv[i].mode; din_a = tv[i].din;
            cyc();
            chk($sformatf("vec%0d_y", i), y_a, pol(tv[i].y));
            chk($sformatf("vec%0d_idx", i), idx_a, tv[i].idx);
            chk($sformatf("vec%0d_wrap", i), wrap_a, tv[i].wrap);
        end

        en_a = 1'b1; mode_a = 1'b1;
        for (int c = 0; c < 30; c++) begin
            int ei;
            cyc();
            ei = (c / 4) % 6;
            chk($sformatf("scan%0d_idx", c), idx_a, ei);
            chk($sformatf("scan%0d_y", c), y_a, pol(oh8(ei)));
            chk($sformatf("scan%0d_wrap", c), wrap_a,
                (c > 0 && c % 4 == 0 && ei == 0));
        end

        mode_a = 1'b0;
        cyc();
        mode_a = 1'b1;
        for (int c = 0; c <= 14; c++) cyc();
        chk("pause_pre_idx", idx_a, 3);
        en_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("pause%0d_y", c), y_a, pol(8'h00));
            chk($sformatf("pause%0d_idx", c), idx_a, 3);
            chk($sformatf("pause%0d_wrap", c), wrap_a, 0);
        end
        en_a = 1'b1;
        cyc();
        chk("resume1_idx", idx_a, 3);
        chk("resume1_y", y_a, pol(8'h08));
        cyc();
        chk("resume2_idx", idx_a, 4);
        chk("resume2_y", y_a, pol(8'h10));

        mode_a = 1'b0;
        cyc();
        mode_a = 1'b1;
        for (int c = 0; c <= 16; c++) cyc();
        chk("prerst_idx", idx_a, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", y_a, pol(8'h00));
        chk("arst_idx", idx_a, 0);
        chk("arst_wrap", wrap_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            cyc();
            chk($sformatf("restart%0d_idx", c), idx_a, (c == 4) ? 1 : 0);
            chk($sformatf("restart%0d_wrap", c), wrap_a, 0);
        end

        mode_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk($sformatf("div1_%0d_idx", c), idx_b, c % 8);
            chk($sformatf("div1_%0d_y", c), y_b, pol(oh8(c % 8)));
            chk($sformatf("div1_%0d_wrap", c), wrap_b, (c > 0 && c % 8 == 0));
        end

        en_a = 1'b1; mode_a = 1'b0; din_a = 3'($urandom_range(0, 7));
        m_scan = 1'b0; m_cnt = 0; m_idx = 0; m_act = 1'b0; m_wrap = 1'b0;
        model_step(en_a, mode_a, din_a);
        cyc();
        for (int k = 0; k < 600; k++) begin
            en_a = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode_a = ~mode_a;
            din_a = 3'($urandom_range(0, 7));
            model_step(en_a, mode_a, din_a);
            cyc();
            chk($sformatf("rnd%0d_y", k), y_a,
                pol(m_act ? oh8(m_idx) : 8'h00));
            chk($sformatf("rnd%0d_idx", k), idx_a, m_idx);
            chk($sformatf("rnd%0d_wrap", k), wrap_a, m_wrap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
